cache_mem_arbiter: RTL and testbench

//  Shares one memory read/write port between the instruction-cache miss path and the

---
 rtl/cache_mem_arbiter_pkg.sv | 17 +
 rtl/cache_mem_arbiter_starve_cnt.sv | 33 +++
 rtl/cache_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_mem_arbiter_pkg: shared state encoding and handshake widths.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cache_mem_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter_starve_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_mem_arbiter_starve_cnt: saturating counter with clear/increment.|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cache_mem_arbiter_starve_cnt
  import cache_mem_arbiter_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // Clear wins over increment; increment holds at MAX.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_mem_arbiter: shares one memory port between I- and D-cache.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int A_WIDTH    = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] i_a,
  input  logic               i_strobe,
  output logic [DATA_W-1:0]  i_dout,
  output logic               i_ready,
  input  logic [A_WIDTH-1:0] d_a,
  input  logic               d_strobe,
  input  logic               d_rw,
  input  logic [DATA_W-1:0]  d_din,
  output logic [DATA_W-1:0]  d_dout,
  output logic               d_ready,
  output logic [A_WIDTH-1:0] m_a,
  output logic               m_strobe,
  output logic               m_rw,
  output logic [DATA_W-1:0]  m_din,
  input  logic [DATA_W-1:0]  m_dout,
  input  logic               m_ready
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_V = CNT_W'(STARVE_MAX);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             cnt_inc;
  logic             cnt_clr;

  assign starved = (starve_cnt == STARVE_V);

  cache_mem_arbiter_starve_cnt #(
    .MAX (STARVE_MAX),
    .W   (CNT_W)
  ) u_starve (
    .clk  (clk),
    .clrn (clrn),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (starve_cnt)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Data side wins unless the instruction side has been passed over STARVE_MAX times.
  always_comb begin
    state_nxt = state;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (d_strobe && !(i_strobe && starved)) begin
          state_nxt = ST_GNT_D;
          cnt_inc   = i_strobe;
          cnt_clr   = !i_strobe;
        end else if (i_strobe) begin
          state_nxt = ST_GNT_I;
          cnt_clr   = 1'b1;
        end
      end
      ST_GNT_I: begin
        if (!i_strobe || m_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GNT_D: begin
        if (!d_strobe || m_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs follow the live strobe so an abort or reset drops m_strobe in the same cycle.
  always_comb begin
    m_strobe = 1'b0;
    m_a      = '0;
    m_rw     = 1'b0;
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    case (state)
      ST_GNT_I: begin
        m_strobe = i_strobe;
        m_a      = i_a;
        i_ready  = m_ready & i_strobe;
      end
      ST_GNT_D: begin
        m_strobe = d_strobe;
        m_a      = d_a;
        m_rw     = d_rw;
        d_ready  = m_ready & d_strobe;
      end
      default: ;
    endcase
  end

  assign m_din  = d_din;
  assign i_dout = m_dout;
  assign d_dout = m_dout;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// Scoreboard bench for cache_mem_arbiter: client drivers, a latency memory model and
// an in-order queue of expected transfers checked whenever a ready fires.
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] i_a, d_a, d_din, i_dout, d_dout, m_a, m_din;
  logic [31:0] m_dout  = 32'h0;
  logic        m_ready = 1'b0;
  logic        i_strobe, d_strobe, d_rw, i_ready, d_ready, m_strobe, m_rw;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    bit          rw;
    logic [31:0] data;
  } txn_t;

  txn_t        sb_q[$];
  txn_t        mon_t;
  bit          bubble_due = 1'b0;
  int          mem_lat = 3;
  int          mem_cnt = 0;
  bit          stray_ready = 1'b0;
  logic [31:0] dl_a[8];
  bit          dl_rw[8];
  logic [31:0] dl_din[8];

  cache_mem_arbiter #(.A_WIDTH(32), .STARVE_MAX(4)) dut (
    .clk(clk), .clrn(clrn),
    .i_a(i_a), .i_strobe(i_strobe), .i_dout(i_dout), .i_ready(i_ready),
    .d_a(d_a), .d_strobe(d_strobe), .d_rw(d_rw), .d_din(d_din),
    .d_dout(d_dout), .d_ready(d_ready),
    .m_a(m_a), .m_strobe(m_strobe), .m_rw(m_rw), .m_din(m_din),
    .m_dout(m_dout), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
  endfunction

  function automatic void push(input bit is_d, input logic [31:0] a, input bit rw,
                               input logic [31:0] wdata);
    txn_t t;
    t.is_d = is_d;
    t.addr = a;
    t.rw   = rw;
    t.data = rw ? wdata : mem_rd(a);
    sb_q.push_back(t);
  endfunction

  // Memory: ready after mem_lat cycles of continuous strobe; stray_ready pokes it while idle.
  always @(posedge clk) begin
    #2;
    if (m_strobe) begin
      mem_cnt++;
      m_ready = (mem_cnt == mem_lat);
    end else begin
      mem_cnt = 0;
      m_ready = stray_ready;
    end
    m_dout = mem_rd(m_a);
  end

  always @(negedge clk) begin
    if (i_ready || d_ready) begin
      if (sb_q.size() == 0) begin
        chk("spurious_ready", {30'd0, i_ready, d_ready}, 32'd0);
      end else begin
        mon_t = sb_q.pop_front();
        chk("ready_both", {31'd0, i_ready & d_ready}, 32'd0);
        chk("ready_client", {31'd0, d_ready}, {31'd0, mon_t.is_d});
        chk("xfer_addr", m_a, mon_t.addr);
        chk("xfer_rw", {31'd0, m_rw}, {31'd0, mon_t.rw});
        if (mon_t.rw) chk("wr_data", m_din, mon_t.data);
        else          chk("rd_data", mon_t.is_d ? d_dout : i_dout, mon_t.data);
      end
      bubble_due = 1'b1;
    end else begin
      if (bubble_due) chk("bubble", {31'd0, m_strobe}, 32'd0);
      bubble_due = 1'b0;
      if (m_strobe && sb_q.size() > 0) begin
        chk("hold_addr", m_a, sb_q[0].addr);
        chk("hold_rw", {31'd0, m_rw}, {31'd0, sb_q[0].rw});
        if (sb_q[0].rw) chk("hold_din", m_din, sb_q[0].data);
      end
    end
  end

  task automatic drive_i(input logic [31:0] a);
    bit done = 1'b0;
    i_a      = a;
    i_strobe = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (i_ready) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("i_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    i_strobe = 1'b0;
  endtask

  // Strobe stays high between back-to-back D requests so it is seen in every IDLE cycle.
  task automatic drive_d(input int n);
    for (int j = 0; j < n; j++) begin
      bit done = 1'b0;
      d_a      = dl_a[j];
      d_rw     = dl_rw[j];
      d_din    = dl_din[j];
      d_strobe = 1'b1;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (d_ready) begin
          done = 1'b1;
          break;
        end
      end
      if (!done) chk("d_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    d_strobe = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clrn = 1'b0; i_strobe = 1'b0; d_strobe = 1'b0; d_rw = 1'b0;
    i_a = '0; d_a = '0; d_din = '0;
    #3;
    chk("rst_m_strobe", {31'd0, m_strobe}, 32'd0);
    chk("rst_m_rw", {31'd0, m_rw}, 32'd0);
    chk("rst_i_ready", {31'd0, i_ready}, 32'd0);
    chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
    chk("rst_m_a", m_a, 32'd0);
    chk("rst_cnt", 32'(dut.starve_cnt), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    clrn = 1'b1;
    @(posedge clk); #1;

    // Instruction-only read
    push(1'b0, 32'h100, 1'b0, 32'h0);
    drive_i(32'h100);

    // Data write
    dl_a[0] = 32'h2000; dl_rw[0] = 1'b1; dl_din[0] = 32'h1234_5678;
    push(1'b1, 32'h2000, 1'b1, 32'h1234_5678);
    drive_d(1);

    // Simultaneous: D first, bubble, then I
    dl_a[0] = 32'h400; dl_rw[0] = 1'b0; dl_din[0] = 32'h0;
    push(1'b1, 32'h400, 1'b0, 32'h0);
    push(1'b0, 32'h300, 1'b0, 32'h0);
    fork
      drive_i(32'h300);
      drive_d(1);
    join

    // Starvation: four D grants, forced I, then remaining D
    for (int k = 0; k < 6; k++) begin
      dl_a[k] = 32'h1000 + 32'(k * 16); dl_rw[k] = 1'b0; dl_din[k] = 32'h0;
    end
    for (int k = 0; k < 4; k++) push(1'b1, dl_a[k], 1'b0, 32'h0);
    push(1'b0, 32'h500, 1'b0, 32'h0);
    for (int k = 4; k < 6; k++) push(1'b1, dl_a[k], 1'b0, 32'h0);
    fork
      drive_i(32'h500);
      drive_d(6);
    join
    chk("starve_cnt_after", 32'(dut.starve_cnt), 32'd0);

    // Abort during an I grant
    i_a = 32'h600; i_strobe = 1'b1;
    @(negedge clk);
    chk("arb_latency", {31'd0, m_strobe}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_granted", {31'd0, m_strobe}, 32'd1);
    chk("abort_addr", m_a, 32'h600);
    @(posedge clk); #1;
    i_strobe = 1'b0;
    #1;
    chk("abort_drop", {31'd0, m_strobe}, 32'd0);
    @(negedge clk);
    chk("abort_no_ready", {31'd0, i_ready}, 32'd0);
    @(posedge clk); #1;
    chk("abort_idle", 32'(dut.state), 32'(ST_IDLE));

    // m_ready seen while IDLE is ignored
    @(posedge clk); #1;
    stray_ready = 1'b1;
    dl_a[0] = 32'h800; dl_rw[0] = 1'b0; dl_din[0] = 32'h0;
    d_a = 32'h800; d_rw = 1'b0; d_strobe = 1'b1;
    push(1'b1, 32'h800, 1'b0, 32'h0);
    @(negedge clk);
    chk("idle_ready_d", {31'd0, d_ready}, 32'd0);
    chk("idle_ready_m", {31'd0, m_strobe}, 32'd0);
    stray_ready = 1'b0;
    drive_d(1);

    // Reset in the middle of a D transfer with I also pending
    d_a = 32'h700; d_rw = 1'b0; d_strobe = 1'b1; i_a = 32'h710; i_strobe = 1'b1;
    @(posedge clk); #1;
    i_strobe = 1'b0;
    @(negedge clk);
    chk("rst_pre_strobe", {31'd0, m_strobe}, 32'd1);
    chk("rst_pre_cnt", 32'(dut.starve_cnt), 32'd1);
    #2;
    clrn = 1'b0;
    #1;
    chk("rst_async_strobe", {31'd0, m_strobe}, 32'd0);
    chk("rst_async_m_a", m_a, 32'd0);
    d_strobe = 1'b0;
    @(posedge clk); #1;
    clrn = 1'b1;
    chk("rst_post_state", 32'(dut.state), 32'(ST_IDLE));
    chk("rst_post_cnt", 32'(dut.starve_cnt), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
